spi_word_fifo: RTL and testbench

- Parametrised successor of the single-pointer SPI buffer: two independent circular FIFOs between the processor word bus and the SPI byte stream.
- TX path: the processor writes whole words; the words are serialised into SPI_DATA_WIDTH chunks, one chunk per spi_ready pulse.
- RX path: SPI chunks are assembled into words that the processor reads with oe.
- Sits between the processor-unit bus and the SPI master/slave shift core; status is reported on attr_out.

---
 rtl/spi_word_fifo.sv | 142 ++++++++++++++
 tb/tb_spi_word_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_fifo.sv
// Word-wide TX/RX circular FIFOs bridging a processor bus and an SPI shift core.
// TX words are split into SPI chunks; received chunks are assembled into RX words.
module spi_word_fifo #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SPI_DATA_WIDTH = 8,
  parameter int unsigned BUF_SIZE       = 16,
  parameter int unsigned ATTR_WIDTH     = 4,
  parameter bit          MSB_FIRST      = 1'b1,
  localparam int unsigned CHUNKS        = DATA_WIDTH / SPI_DATA_WIDTH,
  localparam int unsigned CW            = $clog2(BUF_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      oe,
  output logic [DATA_WIDTH-1:0]     data_out,
  input  logic [ATTR_WIDTH-1:0]     attr_in,
  output logic [ATTR_WIDTH-1:0]     attr_out,
  output logic [SPI_DATA_WIDTH-1:0] spi_data_send,
  input  logic [SPI_DATA_WIDTH-1:0] spi_data_receive,
  input  logic                      spi_ready,
  output logic [CW-1:0]             tx_count,
  output logic [CW-1:0]             rx_count
);

  localparam int unsigned PW = $clog2(BUF_SIZE);
  localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [DATA_WIDTH-1:0] tx_mem [BUF_SIZE];
  logic [DATA_WIDTH-1:0] rx_mem [BUF_SIZE];
  logic [PW-1:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [IW-1:0]         tx_idx, rx_idx;
  logic [DATA_WIDTH-1:0] rx_asm, rx_word, tx_head;
  logic                  overflow, flush;
  logic                  tx_last, tx_pop, tx_push, rx_done, rx_pop, rx_push, ovf_evt;
  logic                  unused_attr;

  assign flush       = attr_in[0];
  assign unused_attr = ^attr_in[ATTR_WIDTH-1:1];

  function automatic int unsigned chunk_lsb(input int unsigned k);
    return MSB_FIRST ? (DATA_WIDTH - (k + 1) * SPI_DATA_WIDTH) : (k * SPI_DATA_WIDTH);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    tx_head       = tx_mem[tx_rd_ptr];
    spi_data_send = '0;
    if (tx_count != '0) spi_data_send = tx_head[chunk_lsb(32'(tx_idx)) +: SPI_DATA_WIDTH];
  end

  // Completed word must include the chunk arriving this cycle.
  always_comb begin
    rx_word = rx_asm;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (32'(rx_idx) == k) rx_word[chunk_lsb(k) +: SPI_DATA_WIDTH] = spi_data_receive;
    end
  end

  always_comb begin
    tx_last = (tx_idx == IW'(CHUNKS - 1));
    tx_pop  = spi_ready && (tx_count != '0) && tx_last;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    tx_push = wr && ((tx_count != CW'(BUF_SIZE)) || tx_pop);
    rx_done = spi_ready && (rx_idx == IW'(CHUNKS - 1));
    rx_pop  = oe && (rx_count != '0);
    rx_push = rx_done && ((rx_count != CW'(BUF_SIZE)) || rx_pop);
    ovf_evt = (wr && !tx_push) || (rx_done && !rx_push);
  end

  always_comb begin
    attr_out    = '0;
    attr_out[0] = (rx_count != '0);
    attr_out[1] = (tx_count == '0);
    attr_out[2] = (tx_count == CW'(BUF_SIZE));
    attr_out[3] = overflow;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= data_in;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (!flush && rx_pop) begin
      data_out <= rx_mem[rx_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      rx_asm    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= ptr_inc(tx_wr_ptr);
      if (spi_ready && (tx_count != '0)) begin
        if (tx_last) begin
          tx_idx    <= '0;
          tx_rd_ptr <= ptr_inc(tx_rd_ptr);
        end else begin
          tx_idx <= tx_idx + IW'(1);
        end
      end
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase

      if (spi_ready) begin
        rx_asm <= rx_word;
        rx_idx <= rx_done ? '0 : rx_idx + IW'(1);
      end
      if (rx_push) rx_wr_ptr <= ptr_inc(rx_wr_ptr);
      if (rx_pop)  rx_rd_ptr <= ptr_inc(rx_rd_ptr);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (ovf_evt) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_word_fifo.sv
// Self-checking bench for spi_word_fifo (default parameters) against a queue-based model.
module tb_spi_word_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = '0;
  logic        oe = 1'b0;
  logic [31:0] data_out;
  logic [3:0]  attr_in = '0;
  logic [3:0]  attr_out;
  logic [7:0]  spi_data_send;
  logic [7:0]  spi_data_receive = '0;
  logic        spi_ready = 1'b0;
  logic [4:0]  tx_count;
  logic [4:0]  rx_count;

  int n_checks = 0;
  int n_pass   = 0;

  spi_word_fifo dut (
    .clk              (clk),
    .rst              (rst),
    .wr               (wr),
    .data_in          (data_in),
    .oe               (oe),
    .data_out         (data_out),
    .attr_in          (attr_in),
    .attr_out         (attr_out),
    .spi_data_send    (spi_data_send),
    .spi_data_receive (spi_data_receive),
    .spi_ready        (spi_ready),
    .tx_count         (tx_count),
    .rx_count         (rx_count)
  );

  always #5 clk = ~clk;

  // Reference model: word queues plus a list of chunks received so far.
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic [7:0]  m_parts[$];
  int          m_sent = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_dout = '0;

  task automatic model_step(input logic w, input logic [31:0] d, input logic o, input logic f,
                            input logic r, input logic [7:0] rc, input logic rs);
    logic        pop, accept;
    logic [31:0] word;
    if (rs || f) begin
      m_tx.delete(); m_rx.delete(); m_parts.delete();
      m_sent = 0; m_ovf = 1'b0;
      if (rs) m_dout = '0;
      return;
    end
    pop    = r && (m_tx.size() > 0) && (m_sent == 3);
    accept = w && ((m_tx.size() < 16) || pop);
    if (r && m_tx.size() > 0) begin
      if (pop) begin void'(m_tx.pop_front()); m_sent = 0; end
      else m_sent++;
    end
    if (accept) m_tx.push_back(d);
    if (w && !accept) m_ovf = 1'b1;
    // Reading first means a word completing this cycle is never seen by this oe.
    if (o && m_rx.size() > 0) m_dout = m_rx.pop_front();
    if (r) begin
      m_parts.push_back(rc);
      if (m_parts.size() == 4) begin
        word = '0;
        foreach (m_parts[i]) word = (word << 8) | 32'(m_parts[i]);
        m_parts.delete();
        if (m_rx.size() < 16) m_rx.push_back(word);
        else m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] exp_send();
    if (m_tx.size() == 0) return 8'h00;
    return 8'((m_tx[0] >> (8 * (3 - m_sent))) & 32'hff);
  endfunction

  function automatic logic [3:0] exp_attr();
    return {m_ovf, m_tx.size() == 16, m_tx.size() == 0, m_rx.size() != 0};
  endfunction

  task automatic step(input logic w, input logic [31:0] d, input logic o, input logic f,
                      input logic r, input logic [7:0] rc, input logic rs);
    wr = w; data_in = d; oe = o; attr_in = {3'b101, f}; spi_ready = r;
    spi_data_receive = rc; rst = rs;
    @(posedge clk);
    model_step(w, d, o, f, r, rc, rs);
    #1;
  endtask

  task automatic idle();            step(0, '0, 0, 0, 0, '0, 0); endtask
  task automatic do_flush();        step(0, '0, 0, 1, 0, '0, 0); endtask
  task automatic do_write(input logic [31:0] d); step(1, d, 0, 0, 0, '0, 0); endtask
  task automatic do_ready(input logic [7:0] rc); step(0, '0, 0, 0, 1, rc, 0); endtask
  task automatic do_read();         step(0, '0, 1, 0, 0, '0, 0); endtask

  task automatic test_reset();
    step(1, 32'hdead_beef, 1, 0, 1, 8'h5a, 1);
    step(0, '0, 0, 0, 0, '0, 1);
    n_checks++; if (attr_out !== 4'b0010) $display("FAIL reset_attr: got %b expected 0010", attr_out); else n_pass++;
    n_checks++; if (tx_count !== 5'd0) $display("FAIL reset_tx_count: got %0d expected 0", tx_count); else n_pass++;
    n_checks++; if (rx_count !== 5'd0) $display("FAIL reset_rx_count: got %0d expected 0", rx_count); else n_pass++;
    n_checks++; if (data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else n_pass++;
    n_checks++; if (spi_data_send !== 8'h0) $display("FAIL reset_send: got %h expected 0", spi_data_send); else n_pass++;
  endtask

  task automatic test_tx_serialise();
    logic [31:0] w = 32'hA1B2C3D4;
    logic [7:0]  exp;
    do_flush();
    do_write(w);
    for (int k = 0; k < 4; k++) begin
      exp = w[31-8*k -: 8];
      n_checks++;
      if (spi_data_send !== exp) $display("FAIL tx_chunk%0d: got %h expected %h", k, spi_data_send, exp);
      else n_pass++;
      do_ready(8'h00);
    end
    n_checks++; if (tx_count !== 5'd0) $display("FAIL tx_drained_count: got %0d expected 0", tx_count); else n_pass++;
    n_checks++; if (attr_out[1] !== 1'b1) $display("FAIL tx_empty_flag: got %b expected 1", attr_out[1]); else n_pass++;
  endtask

  task automatic test_rx_assemble();
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_flush();
    for (int k = 0; k < 8; k++) do_ready(bytes[k]);
    n_checks++; if (rx_count !== 5'd2) $display("FAIL rx_count_two: got %0d expected 2", rx_count); else n_pass++;
    do_read();
    n_checks++; if (data_out !== 32'h11223344) $display("FAIL rx_word0: got %h expected 11223344", data_out); else n_pass++;
    do_read();
    n_checks++; if (data_out !== 32'h55667788) $display("FAIL rx_word1: got %h expected 55667788", data_out); else n_pass++;
    n_checks++; if (attr_out[0] !== 1'b0) $display("FAIL rx_valid_clear: got %b expected 0", attr_out[0]); else n_pass++;
  endtask

  task automatic test_tx_full_wrap();
    do_flush();
    for (int k = 0; k < 16; k++) do_write(32'(k));
    n_checks++; if (attr_out[2] !== 1'b1) $display("FAIL tx_full_flag: got %b expected 1", attr_out[2]); else n_pass++;
    n_checks++; if (attr_out[3] !== 1'b0) $display("FAIL no_ovf_before: got %b expected 0", attr_out[3]); else n_pass++;
    do_write(32'h99);
    n_checks++; if (attr_out[3] !== 1'b1) $display("FAIL tx_ovf_flag: got %b expected 1", attr_out[3]); else n_pass++;
    n_checks++; if (tx_count !== 5'd16) $display("FAIL tx_count_full: got %0d expected 16", tx_count); else n_pass++;
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (spi_data_send !== exp_send()) $display("FAIL drain_chunk%0d: got %h expected %h", k, spi_data_send, exp_send());
      else n_pass++;
      do_ready(8'($urandom));
    end
    n_checks++; if (tx_count !== 5'd0) $display("FAIL drain_count: got %0d expected 0", tx_count); else n_pass++;
    for (int k = 0; k < 3; k++) do_write($urandom);
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (spi_data_send !== exp_send()) $display("FAIL wrap_chunk%0d: got %h expected %h", k, spi_data_send, exp_send());
      else n_pass++;
      do_ready(8'($urandom));
    end
  endtask

  task automatic test_simultaneous();
    do_flush();
    for (int k = 0; k < 16; k++) do_write($urandom);
    for (int k = 0; k < 3; k++) do_ready(8'h00);
    step(1, 32'hCAFE_F00D, 0, 0, 1, 8'h00, 0);
    n_checks++; if (tx_count !== 5'd16) $display("FAIL simul_tx_count: got %0d expected 16", tx_count); else n_pass++;
    n_checks++; if (attr_out[3] !== 1'b0) $display("FAIL simul_no_ovf: got %b expected 0", attr_out[3]); else n_pass++;
    n_checks++; if (spi_data_send !== exp_send()) $display("FAIL simul_next_head: got %h expected %h", spi_data_send, exp_send()); else n_pass++;
    do_flush();
    for (int k = 0; k < 4; k++) do_ready(8'($urandom));
    n_checks++; if (rx_count !== 5'd1) $display("FAIL simul_rx_one: got %0d expected 1", rx_count); else n_pass++;
    for (int k = 0; k < 3; k++) do_ready(8'($urandom));
    step(0, '0, 1, 0, 1, 8'($urandom), 0);
    n_checks++; if (rx_count !== 5'd1) $display("FAIL simul_rx_count: got %0d expected 1", rx_count); else n_pass++;
    n_checks++; if (data_out !== m_dout) $display("FAIL simul_rx_data: got %h expected %h", data_out, m_dout); else n_pass++;
  endtask

  task automatic test_flush_mid_word();
    logic [31:0] keep;
    do_flush();
    for (int k = 0; k < 17; k++) do_write($urandom);
    do_ready(8'hEE);
    do_ready(8'hDD);
    keep = m_dout;
    step(1, 32'h1234_5678, 1, 1, 1, 8'hCC, 0);
    n_checks++; if (attr_out !== 4'b0010) $display("FAIL flush_attr: got %b expected 0010", attr_out); else n_pass++;
    n_checks++; if (data_out !== keep) $display("FAIL flush_keeps_dout: got %h expected %h", data_out, keep); else n_pass++;
    for (int k = 0; k < 4; k++) do_ready(8'(8'h41 + k));
    n_checks++; if (rx_count !== 5'd1) $display("FAIL flush_rx_count: got %0d expected 1", rx_count); else n_pass++;
    n_checks++; if (attr_out[3] !== 1'b0) $display("FAIL flush_ovf_clear: got %b expected 0", attr_out[3]); else n_pass++;
    do_read();
    n_checks++; if (data_out !== 32'h41424344) $display("FAIL flush_word: got %h expected 41424344", data_out); else n_pass++;
  endtask

  task automatic test_random();
    logic w, o, f, r, rs;
    do_flush();
    for (int i = 0; i < 3000; i++) begin
      if (((i / 150) % 2) == 0) begin
        w = ($urandom_range(3) != 0); o = ($urandom_range(7) == 0);
      end else begin
        w = ($urandom_range(7) == 0); o = ($urandom_range(3) != 0);
      end
      r  = $urandom_range(1) == 1;
      f  = ($urandom_range(199) == 0);
      rs = ($urandom_range(499) == 0);
      step(w, $urandom, o, f, r, 8'($urandom), rs);
      n_checks++;
      if (data_out !== m_dout || attr_out !== exp_attr() || tx_count !== 5'(m_tx.size()) ||
          rx_count !== 5'(m_rx.size()) || spi_data_send !== exp_send()) begin
        $display("FAIL random_cycle%0d: got dout=%h attr=%b tx=%0d rx=%0d send=%h expected dout=%h attr=%b tx=%0d rx=%0d send=%h",
                 i, data_out, attr_out, tx_count, rx_count, spi_data_send,
                 m_dout, exp_attr(), m_tx.size(), m_rx.size(), exp_send());
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_serialise();
    test_rx_assemble();
    test_tx_full_wrap();
    test_simultaneous();
    test_flush_mid_word();
    test_random();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
